chip: RTL and testbench

- FPGA top-level demo block for the GMII Ethernet board.
- Takes one differential board clock and an asynchronous active-low push-button reset.
- After reset it releases the PHY and prints a fixed boot banner on a UART pin (F_LED[3]).
- It then transmits one fixed, padded and CRC-terminated ARP request frame on the GMII transmit interface every DMA_RX_INTERVAL clock cycles.

---
 rtl/chip.sv | 275 +++++++++++++++++++++++++++
 tb/tb_chip.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/chip.sv
`default_nettype none
// ============================================================================
//  Module      : chip
//  Description : GMII Ethernet board demo top. Releases the PHY after a fixed
//                delay, prints a boot banner on a UART pin and periodically
//                transmits a fixed ARP request frame with a running CRC-32.
//  Revision    : 1.0 - initial release
// ============================================================================
module chip #(
    parameter int DMA_RX_INTERVAL  = 125000000,
    parameter int UART_BAUD        = 271,
    parameter int PHY_RESET_CYCLES = 1024
) (
    input  logic       FCLKIN_P,
    input  logic       FCLKIN_N,
    input  logic       FPGA_RESET,
    output logic [3:0] F_LED,
    output logic       PHY_RESET,
    output logic       PHY_TXC_GTXCLK,
    input  logic       PHY_TXCLK,
    output logic [7:0] PHY_TXD,
    output logic       PHY_TXCTL_TXEN,
    output logic       PHY_TXER
);

    localparam int c_BIT_CYCLES = 4 * UART_BAUD;
    localparam int c_BAUD_W     = $clog2(c_BIT_CYCLES);
    localparam int c_PHY_W      = $clog2(PHY_RESET_CYCLES + 1);
    localparam int c_DMA_W      = $clog2(DMA_RX_INTERVAL);

    // Frame is 8 header bytes, 60 bytes of payload+pad, 4 FCS bytes.
    localparam logic [6:0] c_CRC_FIRST = 7'd8;
    localparam logic [6:0] c_FCS_FIRST = 7'd68;
    localparam logic [6:0] c_FRAME_END = 7'd72;
    localparam logic [3:0] c_GAP_LAST  = 4'd11;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_SEND = 2'd1;
    localparam logic [1:0] c_S_GAP  = 2'd2;

    // Boot banner "chip ok\r\n".
    function automatic logic [7:0] f_banner(input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h0A;
        case (idx)
            4'd0:    b = 8'h63;
            4'd1:    b = 8'h68;
            4'd2:    b = 8'h69;
            4'd3:    b = 8'h70;
            4'd4:    b = 8'h20;
            4'd5:    b = 8'h6F;
            4'd6:    b = 8'h6B;
            4'd7:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    // Fixed frame image up to the FCS; zero bytes fall to the default arm.
    function automatic logic [7:0] f_frame_byte(input logic [6:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx) inside
            [7'd0:7'd6]:   b = 8'h55;
            7'd7:          b = 8'hD5;
            [7'd8:7'd13]:  b = 8'hFF;
            7'd15, 7'd31:  b = 8'hE0;
            7'd16, 7'd32:  b = 8'h4C;
            7'd17, 7'd33:  b = 8'h68;
            7'd18, 7'd34:  b = 8'hA1;
            7'd19, 7'd35:  b = 8'hBD;
            7'd20, 7'd24:  b = 8'h08;
            7'd21, 7'd26:  b = 8'h06;
            7'd23, 7'd29:  b = 8'h01;
            7'd27:         b = 8'h04;
            7'd36, 7'd46:  b = 8'hC0;
            7'd37, 7'd47:  b = 8'hA8;
            7'd38, 7'd48:  b = 8'h01;
            7'd39:         b = 8'h81;
            7'd49:         b = 8'h0A;
            default:       b = 8'h00;
        endcase
        return b;
    endfunction

    // Reflected CRC-32 (poly 0x04C11DB7) advanced by one byte, LSB first.
    function automatic logic [31:0] f_crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    logic                clk;
    logic                rst_n;
    logic                w_unused;
    logic [1:0]          r_rst_sync;
    logic [26:0]         r_hb_cnt;
    logic [c_PHY_W-1:0]  r_phy_cnt;
    logic                r_phy_ready;
    logic                w_phy_set;
    logic [9:0]          r_uart_shift;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [3:0]          r_bit_cnt;
    logic [3:0]          r_byte_idx;
    logic                r_uart_active;
    logic [c_DMA_W-1:0]  r_tick_cnt;
    logic                w_tick;
    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [6:0]          r_idx;
    logic [3:0]          r_gap_cnt;
    logic [31:0]         r_crc;
    logic [7:0]          w_tx_byte;
    logic [7:0]          r_txd;
    logic                r_txen;
    logic                r_frame_led;

    // Differential input buffer: P high with N low is the clock high phase.
    assign clk            = FCLKIN_P & ~FCLKIN_N;
    assign PHY_TXC_GTXCLK = clk;
    assign w_unused       = PHY_TXCLK;

    // Reset assertion is immediate; release is delayed by two clk flops.
    always_ff @(posedge clk or negedge FPGA_RESET) begin
        if (!FPGA_RESET) r_rst_sync <= 2'b00;
        else             r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign rst_n = r_rst_sync[1];

    // Free-running heartbeat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hb_cnt <= '0;
        else        r_hb_cnt <= r_hb_cnt + 27'd1;
    end

    // PHY release: count out the hold time, then latch ready until next reset.
    assign w_phy_set = !r_phy_ready && (r_phy_cnt == c_PHY_W'(PHY_RESET_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phy_cnt   <= '0;
            r_phy_ready <= 1'b0;
        end else if (!r_phy_ready) begin
            r_phy_cnt <= r_phy_cnt + c_PHY_W'(1);
            if (w_phy_set) r_phy_ready <= 1'b1;
        end
    end

    // UART banner: 10-bit {stop, data, start} frames shifted out LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_uart_shift  <= 10'h3FF;
            r_baud_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_byte_idx    <= '0;
            r_uart_active <= 1'b0;
        end else if (w_phy_set) begin
            r_uart_active <= 1'b1;
            r_uart_shift  <= {1'b1, f_banner(4'd0), 1'b0};
            r_baud_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_byte_idx    <= '0;
        end else if (r_uart_active) begin
            if (r_baud_cnt == c_BAUD_W'(c_BIT_CYCLES - 1)) begin
                r_baud_cnt <= '0;
                if (r_bit_cnt == 4'd9) begin
                    r_bit_cnt <= '0;
                    if (r_byte_idx == 4'd8) begin
                        r_uart_active <= 1'b0;
                        r_uart_shift  <= 10'h3FF;
                    end else begin
                        r_byte_idx   <= r_byte_idx + 4'd1;
                        r_uart_shift <= {1'b1, f_banner(r_byte_idx + 4'd1), 1'b0};
                    end
                end else begin
                    r_bit_cnt    <= r_bit_cnt + 4'd1;
                    r_uart_shift <= {1'b1, r_uart_shift[9:1]};
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
            end
        end
    end

    // Frame timer: wraps every DMA_RX_INTERVAL cycles once the PHY is up.
    assign w_tick = r_phy_ready && (r_tick_cnt == c_DMA_W'(DMA_RX_INTERVAL - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_tick_cnt <= '0;
        else if (r_phy_ready) r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_DMA_W'(1);
    end

    // Transmit state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next state: ticks are only honoured in IDLE, so busy-time ticks are dropped.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (w_tick) w_state_next = c_S_SEND;
            c_S_SEND: if (r_idx == c_FRAME_END) w_state_next = c_S_GAP;
            c_S_GAP:  if (r_gap_cnt == c_GAP_LAST) w_state_next = c_S_IDLE;
            default:  w_state_next = c_S_IDLE;
        endcase
    end

    // Byte to drive at r_idx: fixed image, or complemented CRC LSB first.
    always_comb begin
        w_tx_byte = f_frame_byte(r_idx);
        if (r_idx >= c_FCS_FIRST) begin
            case (r_idx[1:0])
                2'd0:    w_tx_byte = ~r_crc[7:0];
                2'd1:    w_tx_byte = ~r_crc[15:8];
                2'd2:    w_tx_byte = ~r_crc[23:16];
                default: w_tx_byte = ~r_crc[31:24];
            endcase
        end
    end

    // GMII datapath: registered TXD/TXEN, CRC accumulated over bytes 8..67.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_gap_cnt   <= '0;
            r_crc       <= 32'hFFFFFFFF;
            r_txd       <= 8'h00;
            r_txen      <= 1'b0;
            r_frame_led <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_txd  <= 8'h00;
                    r_txen <= 1'b0;
                    if (w_tick) begin
                        r_txd       <= 8'h55;
                        r_txen      <= 1'b1;
                        r_idx       <= 7'd1;
                        r_crc       <= 32'hFFFFFFFF;
                        r_frame_led <= ~r_frame_led;
                    end
                end
                c_S_SEND: begin
                    if (r_idx == c_FRAME_END) begin
                        r_txd     <= 8'h00;
                        r_txen    <= 1'b0;
                        r_gap_cnt <= '0;
                    end else begin
                        r_txd  <= w_tx_byte;
                        r_txen <= 1'b1;
                        r_idx  <= r_idx + 7'd1;
                        if (r_idx >= c_CRC_FIRST && r_idx < c_FCS_FIRST)
                            r_crc <= f_crc_byte(r_crc, w_tx_byte);
                    end
                end
                default: begin
                    r_txd     <= 8'h00;
                    r_txen    <= 1'b0;
                    r_gap_cnt <= r_gap_cnt + 4'd1;
                end
            endcase
        end
    end

    assign F_LED          = {r_uart_shift[0], r_frame_led, r_phy_ready, r_hb_cnt[26]};
    assign PHY_RESET      = r_phy_ready;
    assign PHY_TXD        = r_txd;
    assign PHY_TXCTL_TXEN = r_txen;
    assign PHY_TXER       = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_chip.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chip
//  Description : Self-checking bench for chip: reset values, PHY release
//                timing, UART banner decode, ARP frame content, FCS residue,
//                frame period and mid-frame reset recovery.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chip;

    localparam int DMA  = 2000;
    localparam int BAUD = 10;
    localparam int PHYC = 100;
    localparam int BITC = 4 * BAUD;

    logic       fclk_p = 1'b0;
    logic       fclk_n;
    logic       fpga_reset = 1'b0;
    logic [3:0] f_led;
    logic       phy_reset;
    logic       phy_gtxclk;
    logic [7:0] phy_txd;
    logic       phy_txen;
    logic       phy_txer;

    assign fclk_n = ~fclk_p;
    always #5 fclk_p = ~fclk_p;

    chip #(
        .DMA_RX_INTERVAL (DMA),
        .UART_BAUD       (BAUD),
        .PHY_RESET_CYCLES(PHYC)
    ) dut (
        .FCLKIN_P       (fclk_p),
        .FCLKIN_N       (fclk_n),
        .FPGA_RESET     (fpga_reset),
        .F_LED          (f_led),
        .PHY_RESET      (phy_reset),
        .PHY_TXC_GTXCLK (phy_gtxclk),
        .PHY_TXCLK      (1'b0),
        .PHY_TXD        (phy_txd),
        .PHY_TXCTL_TXEN (phy_txen),
        .PHY_TXER       (phy_txer)
    );

    // Reference data straight from the frame and banner definitions.
    byte unsigned payload [60] = '{
        8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff,
        8'h00, 8'he0, 8'h4c, 8'h68, 8'ha1, 8'hbd,
        8'h08, 8'h06,
        8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
        8'h00, 8'he0, 8'h4c, 8'h68, 8'ha1, 8'hbd,
        8'hc0, 8'ha8, 8'h01, 8'h81,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'hc0, 8'ha8, 8'h01, 8'h0a,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };
    byte unsigned banner [9] = '{8'h63, 8'h68, 8'h69, 8'h70, 8'h20, 8'h6F, 8'h6B, 8'h0D, 8'h0A};

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          phy_rise_cyc = 0;
    int          good_frames = 0;
    int          aborted = 0;
    logic [31:0] model_fcs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_update(input logic [31:0] c, input byte unsigned b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if ((r[0] ^ b[k]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
            else                       r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = v[31-k];
        return r;
    endfunction

    function automatic byte unsigned exp_byte(input int i);
        logic [31:0] f;
        f = model_fcs;
        if (i < 7)       return 8'h55;
        else if (i == 7) return 8'hD5;
        else if (i < 68) return payload[i-8];
        else             return f[8*(i-68) +: 8];
    endfunction

    initial begin
        forever begin
            @(posedge fclk_p);
            cyc++;
        end
    end

    // GMII receiver: collects each TXEN burst and checks timing, content, FCS.
    initial begin
        byte unsigned cur[$];
        int           last_rise = -1;
        logic         prev_en = 1'b0;
        logic         prev_led2 = 1'b0;
        logic [31:0]  res;
        forever begin
            @(negedge fclk_p);
            if (!fpga_reset) last_rise = -1;
            if (phy_txen === 1'b1) begin
                if (!prev_en) begin
                    if (last_rise < 0) check("first_start", cyc - phy_rise_cyc, DMA);
                    else               check("period", cyc - last_rise, DMA);
                    last_rise = cyc;
                    check("led2_toggle", f_led[2], !prev_led2);
                    check("txer", phy_txer, 0);
                    cur.delete();
                end
                cur.push_back(phy_txd);
            end else if (prev_en) begin
                if (!fpga_reset) begin
                    aborted++;
                end else begin
                    check("frame_len", cur.size(), 72);
                    if (cur.size() == 72) begin
                        for (int i = 0; i < 72; i++)
                            check($sformatf("frame_byte%0d", i), cur[i], exp_byte(i));
                        res = 32'hFFFFFFFF;
                        for (int i = 8; i < 72; i++) res = crc_update(res, cur[i]);
                        check("fcs_residue", bitrev32(res), 32'hC704DD7B);
                    end
                    check("gap_txd", phy_txd, 0);
                    good_frames++;
                end
            end
            prev_en   = (phy_txen === 1'b1);
            prev_led2 = f_led[2];
        end
    end

    // Decode one UART byte; exp_gap is the expected wait before its start bit.
    task automatic uart_rx(input int idx, input int exp_gap);
        int         w = 0;
        logic [7:0] d;
        while (f_led[3] !== 1'b0 && w < 1000) begin
            @(negedge fclk_p);
            w++;
        end
        check($sformatf("uart%0d_gap", idx), w, exp_gap);
        repeat (BITC / 2) @(negedge fclk_p);
        check($sformatf("uart%0d_start", idx), f_led[3], 0);
        for (int b = 0; b < 8; b++) begin
            repeat (BITC) @(negedge fclk_p);
            d[b] = f_led[3];
        end
        repeat (BITC) @(negedge fclk_p);
        check($sformatf("uart%0d_stop", idx), f_led[3], 1);
        check($sformatf("uart%0d_data", idx), d, banner[idx]);
    endtask

    // Hold reset for a random time, check reset state, release, check boot.
    task automatic reset_and_boot();
        int hold = $urandom_range(3, 6);
        int n = 0;
        fpga_reset = 1'b0;
        repeat (hold) @(negedge fclk_p);
        check("rst_led", f_led, 4'b1000);
        check("rst_phy", phy_reset, 0);
        check("rst_txd", phy_txd, 0);
        check("rst_txen", phy_txen, 0);
        check("rst_txer", phy_txer, 0);
        #1 fpga_reset = 1'b1;
        while (phy_reset !== 1'b1 && n < PHYC + 100) begin
            @(negedge fclk_p);
            n++;
        end
        check("phy_delay", n, PHYC + 2);
        check("led1", f_led[1], 1);
        phy_rise_cyc = cyc;
        for (int i = 0; i < 9; i++) uart_rx(i, (i == 0) ? 0 : BITC / 2);
        repeat (BITC) @(negedge fclk_p);
        check("uart_idle", f_led[3], 1);
    endtask

    task automatic wait_frames(input int target);
        int t = 0;
        while (good_frames < target && t < 4 * DMA) begin
            @(negedge fclk_p);
            t++;
        end
        check("frames_seen", good_frames >= target, 1);
    endtask

    initial begin
        int t;
        int k;
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) c = crc_update(c, payload[i]);
        model_fcs = ~c;

        reset_and_boot();
        wait_frames(3);

        // Abort a frame partway through and confirm a clean restart.
        t = 0;
        while (phy_txen !== 1'b1 && t < DMA + 500) begin
            @(negedge fclk_p);
            t++;
        end
        check("abort_found_frame", phy_txen, 1);
        k = $urandom_range(24, 36);
        repeat (k) @(negedge fclk_p);
        check("pre_abort_txen", phy_txen, 1);
        #1 fpga_reset = 1'b0;
        #1 check("abort_txen", phy_txen, 0);
        k = good_frames;
        reset_and_boot();
        wait_frames(k + 2);
        check("aborted_frames", aborted, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
